dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the pipelined RV32I core: the memory-side end of the MEM-stage load/store interface. It accepts one request at a time over a valid/ready handshake and inserts a fixed number of wait states. It performs byte/half/word stores with lane masking and returns sign- or zero-extended load data as a single-cycle response pulse. The MEM stage stalls the pipeline from request until `rsp_valid`.

## Interface
Clocking: one clock; reset is asynchronous and active-high.

Parameters:
- `DEPTH_WORDS`, 256: memory size in 32-bit words; power of two.
- `LATENCY`, 2: wait-state cycles between acceptance and response; range 0..15.

Ports:
- `clk`, in, 1: clock, rising edge.
- `clr`, in, 1: asynchronous active-high reset.
- `req_valid`, in, 1: request present.
- `req_ready`, out, 1: responder idle; can accept a request.
- `req_write`, in, 1: 1 = store, 0 = load.
- `req_func3`, in, 3: RV32I funct3 width/sign code.
- `req_addr`, in, 32: byte address, from the ALU result.
- `req_wdata`, in, 32: store data; the valid bytes are in the low lanes.
- `rsp_valid`, out, 1: one-cycle response pulse.
- `rsp_rdata`, out, 32: extended load data; 0 for stores and errors.
- `rsp_err`, out, 1: access fault, qualified by `rsp_valid`.

## Operation
- FSM states:
  - IDLE: `req_ready`=1.
  - WAIT: counts `LATENCY` cycles.
  - RESP: `rsp_valid`=1 for exactly one cycle.
- Transitions:
  - IDLE→WAIT on `req_valid & req_ready`.
  - If `LATENCY`==0, IDLE→RESP directly.
  - WAIT→RESP when the counter reaches `LATENCY`-1.
  - RESP→IDLE unconditionally. There is no response backpressure.
- Request capture: on acceptance, latch `req_write`, `req_func3`, `req_addr` and `req_wdata`. Inputs are ignored outside IDLE.
- Word index is `addr[log2(DEPTH_WORDS)+1:2]`. Byte lane is `addr[1:0]`.
- Loads:
  - LB (000) and LH (001) sign-extend.
  - LW (010) returns the full word.
  - LBU (100) and LHU (101) zero-extend.
  - The selected byte or half comes from lane `addr[1:0]` (half: `addr[1]`).
- Stores:
  - SB (000) writes only lane `addr[1:0]` with `wdata[7:0]`.
  - SH (001) writes half `addr[1]` with `wdata[15:0]`.
  - SW (010) writes all four bytes.
  - Unselected bytes are unchanged.
- Errors: each of the following gives `rsp_err`=1, `rsp_rdata`=0 and no memory write.
  - Illegal funct3: load 011/110/111; store 011–111.
  - Address ≥ `DEPTH_WORDS*4`.
- The memory array is not reset. Contents after reset are undefined to the bench. Tests pre-write every address they read.

## Timing
- Reset values: `req_ready`=1 (IDLE), `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0; counter 0.
- Response latency: if a request is accepted in cycle N, `rsp_valid` is high in cycle N+1+`LATENCY`. `req_ready` is low from N+1 through N+1+`LATENCY`.
- Back-to-back requests: the next accept is possible at the earliest in cycle N+2+`LATENCY`.
- `rsp_rdata` and `rsp_err` are registered and stable during the RESP cycle. `rsp_rdata` returns to 0 the cycle after RESP.
- Store commit: the write is applied at the clock edge that ends the RESP cycle. A load accepted afterwards returns the new data.
- Load read: the array is read on the edge entering RESP.
- Reset mid-operation (`clr` in WAIT or RESP):
  - The transaction is aborted and the FSM goes to IDLE immediately.
  - A pending store is discarded; no partial write.
  - `rsp_valid` drops asynchronously.
- If `req_valid` is asserted during RESP, it is not accepted until IDLE.

## Configuration
- `DMEM_ALIGN_CHECK_EN` defined:
  - Misaligned accesses give `rsp_err`=1, with no write and `rsp_rdata`=0.
  - Misaligned means a half with `addr[0]`=1, or a word with `addr[1:0]`≠0.
- Undefined:
  - Misaligned offset bits are forced to natural alignment: a half uses `addr[1]` only; a word ignores `addr[1:0]`.
  - The access completes normally; `rsp_err` reflects only funct3 and range errors.

## Structure
- Shared package `dmem_pkg`:
  - funct3 constants `F3_B`=000, `F3_H`=001, `F3_W`=010, `F3_BU`=100, `F3_HU`=101.
  - FSM state enum {IDLE, WAIT, RESP}.
  - `LATENCY` counter width constant (4).
- Sub-module `dmem_lane_align`: a combinational block providing store byte-enable/replicate, load lane select and extension, and the misalignment/illegal-funct3 flags. It is instantiated once; the FSM and array stay in `dmem_responder`.

## Test plan
- Reset, then SW 0x12345678 @0x10, then LW @0x10 with `LATENCY`=2 → `rsp_valid` exactly 3 cycles after each accept, `rdata`=0x12345678, `err`=0.
- After SW 0x80FF7F01 @0x20: LB @0x23 → 0xFFFFFF80; LBU @0x23 → 0x00000080; LH @0x22 → 0xFFFF80FF; LHU @0x20 → 0x00007F01.
- SB 0xAA @0x21 over word 0x11223344 → LW @0x20 returns 0x1122AA44; SH 0xBEEF @0x22 → 0xBEEFAA44.
- LW @0x22:
  - with `DMEM_ALIGN_CHECK_EN` → `err`=1, `rdata`=0, memory unchanged;
  - without it → returns the word @0x20, `err`=0.
- Out-of-range LW @`DEPTH_WORDS*4` → `err`=1; store with funct3=011 → `err`=1 and no write.
- SW issued, `clr` pulsed during WAIT → no `rsp_valid`, `req_ready`=1 after reset, LW of that address returns the pre-store value. With `LATENCY`=0 → response in cycle N+1.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  // Width of the wait-state counter; covers LATENCY 0..15.
  localparam int unsigned CNT_W = 4;

  // RV32I load/store funct3 width and sign codes.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Responder FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // One MEM-stage request as captured on acceptance.
  typedef struct packed {
    logic        write;
    logic [2:0]  func3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dmem_req_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data memory: store byte enables and data
// replication, load lane select with sign/zero extension, and the
// illegal-funct3 / misalignment flags.
// Misalignment faults are reported only when DMEM_ALIGN_CHECK_EN is defined;
// otherwise half and word accesses are forced to natural alignment.
module dmem_lane_align (
  input  logic        is_write,
  input  logic [2:0]  func3,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be_c,
  output logic [31:0] wdata_c,
  output logic [31:0] rdata_c,
  output logic        misalign_c,
  output logic        illegal_c
);
  import dmem_pkg::*;

  logic [7:0]  byte_sel_c;
  logic [15:0] half_sel_c;

  // Lane selection from the addressed word; halves use addr[1] only.
  always_comb begin
    byte_sel_c = 8'(rword >> {lane, 3'b000});
    half_sel_c = lane[1] ? rword[31:16] : rword[15:0];
  end

  // Store enables/replication and load extension by funct3.
  always_comb begin
    be_c      = 4'b0000;
    wdata_c   = 32'h0;
    rdata_c   = 32'h0;
    illegal_c = 1'b0;
    if (is_write) begin
      case (func3)
        F3_B: begin
          be_c    = 4'b0001 << lane;
          wdata_c = {4{wdata[7:0]}};
        end
        F3_H: begin
          be_c    = lane[1] ? 4'b1100 : 4'b0011;
          wdata_c = {2{wdata[15:0]}};
        end
        F3_W: begin
          be_c    = 4'b1111;
          wdata_c = wdata;
        end
        default: illegal_c = 1'b1;
      endcase
    end else begin
      case (func3)
        F3_B:    rdata_c = {{24{byte_sel_c[7]}}, byte_sel_c};
        F3_H:    rdata_c = {{16{half_sel_c[15]}}, half_sel_c};
        F3_W:    rdata_c = rword;
        F3_BU:   rdata_c = {24'h0, byte_sel_c};
        F3_HU:   rdata_c = {16'h0, half_sel_c};
        default: illegal_c = 1'b1;
      endcase
    end
  end

  // Misaligned half (addr[0]) or word (addr[1:0]) detection.
`ifdef DMEM_ALIGN_CHECK_EN
  assign misalign_c = (((func3 == F3_H) || (func3 == F3_HU)) && lane[0]) ||
                      ((func3 == F3_W) && (lane != 2'b00));
`else
  assign misalign_c = 1'b0;
`endif

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the RV32I MEM-stage load/store port.
// Accepts one request at a time, waits LATENCY cycles, then emits a
// single-cycle response; stores commit at the end of the response cycle.
// Optional misalignment faults: define DMEM_ALIGN_CHECK_EN.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  import dmem_pkg::*;

  localparam int unsigned AW      = $clog2(DEPTH_WORDS);
  localparam int unsigned BYTE_AW = AW + 2;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dmem_req_t        req_q, req_d;
  logic             ready_q, ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q, rsp_err_d;

  logic [31:0]      mem_q [DEPTH_WORDS];

  dmem_req_t        cur_c;
  logic [AW-1:0]    widx_c;
  logic [31:0]      rword_c;
  logic             range_err_c;
  logic             err_c;
  logic             mem_we_c;
  logic [3:0]       be_c;
  logic [31:0]      wdata_rep_c;
  logic [31:0]      rdata_ext_c;
  logic             misalign_c;
  logic             illegal_c;

  // Live request in IDLE (zero-latency path), captured request otherwise.
  always_comb begin
    cur_c = req_q;
    if (state_q == IDLE) begin
      cur_c = '{write: req_write, func3: req_func3, addr: req_addr, wdata: req_wdata};
    end
  end

  // Word index, range check and array read for the current request.
  always_comb begin
    widx_c      = cur_c.addr[BYTE_AW-1:2];
    range_err_c = |cur_c.addr[31:BYTE_AW];
    rword_c     = mem_q[widx_c];
    err_c       = range_err_c | illegal_c | misalign_c;
  end

  dmem_lane_align u_lane_align (
    .is_write   (cur_c.write),
    .func3      (cur_c.func3),
    .lane       (cur_c.addr[1:0]),
    .wdata      (cur_c.wdata),
    .rword      (rword_c),
    .be_c       (be_c),
    .wdata_c    (wdata_rep_c),
    .rdata_c    (rdata_ext_c),
    .misalign_c (misalign_c),
    .illegal_c  (illegal_c)
  );

  // Next-state, capture and response computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'h0;
    rsp_err_d   = 1'b0;
    mem_we_c    = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_d = cur_c;
          cnt_d = '0;
          if (LATENCY == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == CNT_W'(LATENCY - 1)) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d  = IDLE;
        mem_we_c = req_q.write & ~err_c;
      end
      default: state_d = IDLE;
    endcase

    // Load data is sampled on the edge that enters RESP.
    if ((state_d == RESP) && (state_q != RESP)) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = err_c;
      rsp_rdata_d = (!cur_c.write && !err_c) ? rdata_ext_c : 32'h0;
    end

    ready_d = (state_d == IDLE);
  end

  // Control and response registers; reset aborts any transaction.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Store commit with byte-lane masking at the end of RESP; array is not reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int i = 0; i < 4; i++) begin
        if (be_c[i]) begin
          mem_q[widx_c][8*i +: 8] <= wdata_rep_c[8*i +: 8];
        end
      end
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance at LATENCY=2, one at LATENCY=0.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int unsigned DEPTH = 256;

  logic        clk = 1'b0;
  logic        clr;

  logic        req_valid, req_write;
  logic [2:0]  req_func3;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  logic        req_valid_z, req_write_z;
  logic [2:0]  req_func3_z;
  logic [31:0] req_addr_z, req_wdata_z;
  logic        req_ready_z, rsp_valid_z, rsp_err_z;
  logic [31:0] rsp_rdata_z;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) u_dut (
    .clk(clk), .clr(clr),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) u_dut_z (
    .clk(clk), .clr(clr),
    .req_valid(req_valid_z), .req_ready(req_ready_z), .req_write(req_write_z),
    .req_func3(req_func3_z), .req_addr(req_addr_z), .req_wdata(req_wdata_z),
    .rsp_valid(rsp_valid_z), .rsp_rdata(rsp_rdata_z), .rsp_err(rsp_err_z)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One full transaction; checks handshake timing and returns the response.
  task automatic xact(input bit zl, input logic wr, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic err);
    int lat;
    int exp_lat;
    exp_lat = zl ? 1 : 3;
    lat     = 0;
    rdata   = 32'h0;
    err     = 1'b0;
    @(negedge clk);
    if (zl) begin
      check("idle_ready", 32'(req_ready_z), 32'd1);
      req_valid_z = 1'b1; req_write_z = wr; req_func3_z = f3;
      req_addr_z  = addr; req_wdata_z = wdata;
    end else begin
      check("idle_ready", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_write = wr; req_func3 = f3;
      req_addr  = addr; req_wdata = wdata;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid   = 1'b0;
    req_valid_z = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (k == 1) check("busy_ready", 32'(zl ? req_ready_z : req_ready), 32'd0);
      if (zl ? rsp_valid_z : rsp_valid) begin
        lat   = k;
        rdata = zl ? rsp_rdata_z : rsp_rdata;
        err   = zl ? rsp_err_z : rsp_err;
        break;
      end
      @(negedge clk);
    end
    check("latency", 32'(lat), 32'(exp_lat));
    @(negedge clk);
    check("pulse_end", 32'(zl ? rsp_valid_z : rsp_valid), 32'd0);
    check("rdata_zero", zl ? rsp_rdata_z : rsp_rdata, 32'h0);
  endtask

  task automatic op(input string tag, input bit zl, input logic wr, input logic [2:0] f3,
                    input logic [31:0] addr, input logic [31:0] wdata,
                    input logic [31:0] exp_rdata, input logic exp_err);
    logic [31:0] rd;
    logic        er;
    xact(zl, wr, f3, addr, wdata, rd, er);
    check({tag, "_rdata"}, rd, exp_rdata);
    check({tag, "_err"}, 32'(er), 32'(exp_err));
  endtask

  initial begin
    int cnt;
    clr = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_func3 = 3'b0; req_addr = 32'h0; req_wdata = 32'h0;
    req_valid_z = 1'b0; req_write_z = 1'b0; req_func3_z = 3'b0; req_addr_z = 32'h0; req_wdata_z = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", rsp_rdata, 32'h0);
    check("rst_err", 32'(rsp_err), 32'd0);
    clr = 1'b0;

    // Basic word store and load
    op("sw10", 0, 1, F3_W, 32'h10, 32'h12345678, 32'h0, 0);
    op("lw10", 0, 0, F3_W, 32'h10, 32'h0, 32'h12345678, 0);

    // Load extension from each lane
    op("sw20", 0, 1, F3_W, 32'h20, 32'h80FF7F01, 32'h0, 0);
    op("lb23", 0, 0, F3_B,  32'h23, 32'h0, 32'hFFFFFF80, 0);
    op("lbu23", 0, 0, F3_BU, 32'h23, 32'h0, 32'h00000080, 0);
    op("lh22", 0, 0, F3_H,  32'h22, 32'h0, 32'hFFFF80FF, 0);
    op("lhu20", 0, 0, F3_HU, 32'h20, 32'h0, 32'h00007F01, 0);
    op("lb21", 0, 0, F3_B,  32'h21, 32'h0, 32'h0000007F, 0);

    // Sub-word stores leave other lanes intact
    op("sw20b", 0, 1, F3_W, 32'h20, 32'h11223344, 32'h0, 0);
    op("sb21", 0, 1, F3_B, 32'h21, 32'hFFFFFFAA, 32'h0, 0);
    op("lw20a", 0, 0, F3_W, 32'h20, 32'h0, 32'h1122AA44, 0);
    op("sh22", 0, 1, F3_H, 32'h22, 32'h1234BEEF, 32'h0, 0);
    op("lw20b", 0, 0, F3_W, 32'h20, 32'h0, 32'hBEEFAA44, 0);

    // Misaligned accesses
`ifdef DMEM_ALIGN_CHECK_EN
    op("lw22", 0, 0, F3_W, 32'h22, 32'h0, 32'h0, 1);
    op("lh21", 0, 0, F3_H, 32'h21, 32'h0, 32'h0, 1);
    op("sw21", 0, 1, F3_W, 32'h21, 32'h01020304, 32'h0, 1);
`else
    op("lw22", 0, 0, F3_W, 32'h22, 32'h0, 32'hBEEFAA44, 0);
    op("lh21", 0, 0, F3_H, 32'h21, 32'h0, 32'hFFFFAA44, 0);
    op("sw21", 0, 1, F3_W, 32'h24, 32'h01020304, 32'h0, 0);
`endif
    op("lw20c", 0, 0, F3_W, 32'h20, 32'h0, 32'hBEEFAA44, 0);

    // Range boundary and illegal funct3
    op("sw3fc", 0, 1, F3_W, 32'h3FC, 32'h5A5A0001, 32'h0, 0);
    op("lw3fc", 0, 0, F3_W, 32'h3FC, 32'h0, 32'h5A5A0001, 0);
    op("lw400", 0, 0, F3_W, DEPTH * 4, 32'h0, 32'h0, 1);
    op("sw400", 0, 1, F3_W, 32'h420, 32'hFFFFFFFF, 32'h0, 1);
    op("st011", 0, 1, 3'b011, 32'h20, 32'hFFFFFFFF, 32'h0, 1);
    op("ld110", 0, 0, 3'b110, 32'h20, 32'h0, 32'h0, 1);
    op("lw20d", 0, 0, F3_W, 32'h20, 32'h0, 32'hBEEFAA44, 0);

    // Reset during WAIT aborts a pending store
    op("sw30", 0, 1, F3_W, 32'h30, 32'hCAFEF00D, 32'h0, 0);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_func3 = F3_W; req_addr = 32'h30; req_wdata = 32'hDEADBEEF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    clr = 1'b1;
    #1;
    check("clr_ready", 32'(req_ready), 32'd1);
    check("clr_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    clr = 1'b0;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) cnt++;
    end
    check("clr_no_rsp", 32'(cnt), 32'd0);
    check("clr_ready2", 32'(req_ready), 32'd1);
    op("lw30", 0, 0, F3_W, 32'h30, 32'h0, 32'hCAFEF00D, 0);

    // Zero-latency instance responds in the following cycle
    op("z_sw40", 1, 1, F3_W, 32'h40, 32'h0BADF00D, 32'h0, 0);
    op("z_lw40", 1, 0, F3_W, 32'h40, 32'h0, 32'h0BADF00D, 0);
    op("z_lhu42", 1, 0, F3_HU, 32'h42, 32'h0, 32'h00000BAD, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
